// File: rtl/key_scan_rx.sv
// key_scan_rx: debounced active-low key inputs with press/release pulses and an event FIFO.
// Define KEY_SCAN_RELEASE_EVT_EN to queue release events as well; by default only presses are queued.
module key_scan_rx #(
  parameter int          NUM_KEYS       = 4,
  parameter logic [15:0] TICK_LIMIT     = 16'd49999,
  parameter int          DEBOUNCE_TICKS = 20,
  parameter int          FIFO_DEPTH     = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                en,
  input  logic [NUM_KEYS-1:0] KEY_in,
  output logic [NUM_KEYS-1:0] key_state,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic                evt_valid,
  input  logic                evt_ready,
  output logic [7:0]          evt_data,
  output logic                evt_overflow,
  input  logic                ovf_clr
);

  localparam int             PTR_W   = $clog2(FIFO_DEPTH);
  localparam logic [4:0]     DB_LAST = 5'(DEBOUNCE_TICKS - 1);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(FIFO_DEPTH);

  logic [NUM_KEYS-1:0]      sync1_q, sync2_q, raw;
  logic [15:0]              tickCnt_q, tickCnt_d;
  logic                     tick;
  logic [NUM_KEYS-1:0][4:0] dbCnt_q, dbCnt_d;
  logic [NUM_KEYS-1:0]      stable_q, stable_d;
  logic [NUM_KEYS-1:0]      keyState_q, keyPress_q, keyRelease_q;
  logic [NUM_KEYS-1:0]      pendPress_q, pendPress_d, pendRel_q, pendRel_d;
  logic [NUM_KEYS-1:0]      clrPress, clrRel, relSet;
  logic                     pushValid;
  logic [7:0]               pushData;
  logic [7:0]               mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]         wrPtr_q, rdPtr_q;
  logic [PTR_W:0]           count_q, count_d;
  logic                     fifoFull, pop, pushOk, dropped;
  logic                     ovf_q, ovf_d;

  // Synchronizer flops reset to 1 so the keys start out released.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= KEY_in;
      sync2_q <= sync1_q;
    end
  end

  assign raw = ~sync2_q;

  always_comb begin
    tick      = en && (tickCnt_q == TICK_LIMIT);
    tickCnt_d = tickCnt_q + 16'd1;
    if (!en || tick) tickCnt_d = '0;
  end

  always_comb begin
    dbCnt_d  = dbCnt_q;
    stable_d = stable_q;
    if (tick) begin
      for (int k = 0; k < NUM_KEYS; k++) begin
        if (raw[k] == stable_q[k]) begin
          dbCnt_d[k] = '0;
        end else if (dbCnt_q[k] == DB_LAST) begin
          dbCnt_d[k]  = '0;
          stable_d[k] = ~stable_q[k];
        end else begin
          dbCnt_d[k] = dbCnt_q[k] + 5'd1;
        end
      end
    end
  end

  // keyState_q lags stable_q by one clock; the pulses mark the first cycle of the new level.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tickCnt_q    <= '0;
      dbCnt_q      <= '0;
      stable_q     <= '0;
      keyState_q   <= '0;
      keyPress_q   <= '0;
      keyRelease_q <= '0;
    end else begin
      tickCnt_q    <= tickCnt_d;
      dbCnt_q      <= dbCnt_d;
      stable_q     <= stable_d;
      keyState_q   <= stable_q;
      keyPress_q   <= stable_q & ~keyState_q;
      keyRelease_q <= ~stable_q & keyState_q;
    end
  end

  assign key_state   = keyState_q;
  assign key_press   = keyPress_q;
  assign key_release = keyRelease_q;

  // Scan from the top so the lowest index, and press over release, is the last assignment kept.
  always_comb begin
    pushValid = 1'b0;
    pushData  = 8'h00;
    clrPress  = '0;
    clrRel    = '0;
    for (int k = NUM_KEYS - 1; k >= 0; k--) begin
      if (pendRel_q[k]) begin
        pushValid = 1'b1;
        pushData  = {1'b0, 7'(k)};
        clrPress  = '0;
        clrRel    = '0;
        clrRel[k] = 1'b1;
      end
      if (pendPress_q[k]) begin
        pushValid   = 1'b1;
        pushData    = {1'b1, 7'(k)};
        clrPress    = '0;
        clrRel      = '0;
        clrPress[k] = 1'b1;
      end
    end
  end

`ifdef KEY_SCAN_RELEASE_EVT_EN
  assign relSet = keyRelease_q;
`else
  assign relSet = '0;
`endif

  assign pendPress_d = (pendPress_q & ~clrPress) | keyPress_q;
  assign pendRel_d   = (pendRel_q & ~clrRel) | relSet;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pendPress_q <= '0;
      pendRel_q   <= '0;
    end else begin
      pendPress_q <= pendPress_d;
      pendRel_q   <= pendRel_d;
    end
  end

  assign fifoFull  = (count_q == DEPTH_C);
  assign evt_valid = (count_q != '0);
  assign pop       = evt_valid && evt_ready;
  assign pushOk    = pushValid && (!fifoFull || pop);
  assign dropped   = pushValid && fifoFull && !pop;
  assign evt_data  = evt_valid ? mem_q[rdPtr_q] : 8'h00;

  always_comb begin
    count_d = count_q;
    case ({pushOk, pop})
      2'b10:   count_d = count_q + (PTR_W + 1)'(1);
      2'b01:   count_d = count_q - (PTR_W + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // A drop in the same cycle as a clear leaves the flag set.
  assign ovf_d        = dropped ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);
  assign evt_overflow = ovf_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 8'h00;
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (pushOk) begin
        mem_q[wrPtr_q] <= pushData;
        wrPtr_q        <= wrPtr_q + PTR_W'(1);
      end
      if (pop) rdPtr_q <= rdPtr_q + PTR_W'(1);
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule
